// File: rtl/cfs_apb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfs_apb_master_pkg
// Description : Shared types and width constants for the APB initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package cfs_apb_master_pkg;

    // Upper bounds on the bus widths the initiator may be built with.
    // APB tops out at 32 bits for both address and data.
    localparam int CFS_APB_MAX_ADDR_WIDTH = 32;
    localparam int CFS_APB_MAX_DATA_WIDTH = 32;

    // Default build widths and timeout.
    localparam int CFS_APB_DEF_ADDR_WIDTH     = 16;
    localparam int CFS_APB_DEF_DATA_WIDTH     = 32;
    localparam int CFS_APB_DEF_TIMEOUT_CYCLES = 16;

    // Transfer phase of the initiator.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } cfs_apb_master_state_t;

    // Registered response presented to the requester.
    typedef struct packed {
        logic [CFS_APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                              slverr;
        logic                              timeout;
    } cfs_apb_master_resp_t;

endpackage
`default_nettype wire

// File: rtl/cfs_apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : cfs_apb_master_if
// Description : Request/response channel plus APB bus signals of the
//               initiator. The master modport is the initiator's view; the
//               slave modport is the view of whatever drives requests and
//               models the APB completer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cfs_apb_master_if
    import cfs_apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = CFS_APB_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = CFS_APB_DEF_DATA_WIDTH
) ();

    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_slverr;
    logic                  resp_timeout;

    // APB bus
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_slverr, resp_timeout,
        input  resp_ready,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_slverr, resp_timeout,
        output resp_ready,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/cfs_apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : cfs_apb_timeout_cnt
// Description : ACCESS-phase wait counter. expired flags the last permitted
//               wait cycle so the caller can abort in that same cycle.
//               A LIMIT of 0 removes the counter entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  wire logic pclk,
    input  wire logic preset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int                   c_CNT_W = $clog2(LIMIT + 1);
            localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(LIMIT - 1);
            localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);

            logic [c_CNT_W-1:0] r_cnt;

            // Count stalled ACCESS cycles; the caller aborts at c_LAST, so
            // the counter never reaches a value where it could wrap.
            always_ff @(posedge pclk or posedge preset) begin
                if (preset) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable && (r_cnt != c_LAST)) begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end

            assign expired = enable && (r_cnt == c_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cfs_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : cfs_apb_master
// Description : APB initiator. Turns a valid/ready request into one APB
//               SETUP/ACCESS transfer and returns a registered response.
//               One transfer in flight; an optional PREADY timeout aborts a
//               stalled ACCESS phase with slverr+timeout set.
//               ADDR_WIDTH/DATA_WIDTH must not exceed the package maxima.
// Revision    : 1.0 - initial release
// ============================================================================
module cfs_apb_master
    import cfs_apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = CFS_APB_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CFS_APB_DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = CFS_APB_DEF_TIMEOUT_CYCLES
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    cfs_apb_master_if.master    bus
);

    cfs_apb_master_state_t  r_state;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic                   r_resp_valid;
    cfs_apb_master_resp_t   r_resp;

    logic                   w_req_ready;
    logic                   w_expired;
    logic                   w_cnt_clear;
    logic                   w_cnt_enable;

    // The only combinational output: accept a request when idle and the
    // previous response has been consumed.
    assign w_req_ready  = (r_state == IDLE) && !r_resp_valid;

    // Counter restarts in SETUP so the first ACCESS cycle sees zero.
    assign w_cnt_clear  = (r_state == SETUP);
    assign w_cnt_enable = (r_state == ACCESS) && !bus.pready;

    cfs_apb_timeout_cnt #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    // Transfer FSM with registered APB controls and response register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state      <= IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
        end else begin
            // Response handshake; contents simply stay until overwritten.
            if (r_resp_valid && bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (bus.req_valid && w_req_ready) begin
                        r_paddr  <= bus.req_addr;
                        r_pwrite <= bus.req_write;
                        r_pwdata <= bus.req_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    // A ready slave wins over an expiring timeout.
                    if (bus.pready) begin
                        r_psel         <= 1'b0;
                        r_penable      <= 1'b0;
                        r_state        <= IDLE;
                        r_resp_valid   <= 1'b1;
                        r_resp.slverr  <= bus.pslverr;
                        r_resp.timeout <= 1'b0;
                        // Select rather than mask so X on prdata during
                        // writes or errors cannot reach the response.
                        r_resp.rdata   <= (!r_pwrite && !bus.pslverr)
                                          ? CFS_APB_MAX_DATA_WIDTH'(bus.prdata)
                                          : '0;
                    end else if (w_expired) begin
                        r_psel         <= 1'b0;
                        r_penable      <= 1'b0;
                        r_state        <= IDLE;
                        r_resp_valid   <= 1'b1;
                        r_resp.slverr  <= 1'b1;
                        r_resp.timeout <= 1'b1;
                        r_resp.rdata   <= '0;
                    end
                end

                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.psel         = r_psel;
    assign bus.penable      = r_penable;
    assign bus.pwrite       = r_pwrite;
    assign bus.paddr        = r_paddr;
    assign bus.pwdata       = r_pwdata;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_rdata   = r_resp.rdata[DATA_WIDTH-1:0];
    assign bus.resp_slverr  = r_resp.slverr;
    assign bus.resp_timeout = r_resp.timeout;

endmodule
`default_nettype wire
